// File: rtl/vecmat_mul_stream_pkg.sv
// Shared constants and helpers for the streaming lane-wise fixed-point multiplier.
package vecmat_mul_stream_pkg;
  localparam logic [1:0] RND_TRUNC = 2'd0;
  localparam logic [1:0] RND_FLOOR = 2'd1;
  localparam logic [1:0] RND_RHAZ  = 2'd2;

  // LSB position of lane i in a packed LANES*dw operand.
  function automatic int lane_lo(input int i, input int dw);
    return i * dw;
  endfunction
endpackage

// File: rtl/vecmat_mul_lane.sv
// One lane: S1 product register, then S2 rescale/round/saturate register.
module vecmat_mul_lane
  import vecmat_mul_stream_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ld1,
  input  logic                 i_ld2,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic [1:0]           i_mode,
  output logic [DW-1:0]        o_res,
  output logic                 o_sat
);
  localparam int PW = 2 * DW;
  // One extra bit so |min*min| = 2^(2DW-2) plus the rounding half never overflows.
  localparam int XW = 2 * DW + 1;
  localparam logic signed [XW-1:0] MAXV = XW'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [XW-1:0] MINV = -MAXV - XW'(1);
  localparam logic [XW-1:0]        HALF = XW'(64'd1 << (FRAC - 1));

  logic signed [PW-1:0] r_p;
  logic [DW-1:0]        r_res;
  logic                 r_sat;

  logic signed [XW-1:0] w_px, w_r;
  logic [XW-1:0]        w_abs, w_mag;
  logic                 w_neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_p <= '0;
    else if (i_ld1) r_p <= PW'(i_a) * PW'(i_b);
  end

  always_comb begin
    w_px  = XW'(r_p);
    w_neg = w_px[XW-1];
    w_abs = w_neg ? XW'(-w_px) : XW'(w_px);
    w_mag = (w_abs + ((i_mode == RND_RHAZ) ? HALF : '0)) >> FRAC;
    case (i_mode)
      RND_FLOOR: w_r = w_px >>> FRAC;
      default:   w_r = w_neg ? -$signed(w_mag) : $signed(w_mag);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res <= '0;
      r_sat <= 1'b0;
    end else if (i_ld2) begin
      if (w_r > MAXV) begin
        r_res <= MAXV[DW-1:0];
        r_sat <= 1'b1;
      end else if (w_r < MINV) begin
        r_res <= MINV[DW-1:0];
        r_sat <= 1'b1;
      end else begin
        r_res <= w_r[DW-1:0];
        r_sat <= 1'b0;
      end
    end
  end

  assign o_res = r_res;
  assign o_sat = r_sat;
endmodule

// File: rtl/vecmat_mul_stream.sv
// LANES-wide signed fixed-point multiplier, 3-stage valid/ready pipeline with full backpressure.
module vecmat_mul_stream
  import vecmat_mul_stream_pkg::*;
#(
  parameter int LANES = 64,
  parameter int DW    = 16,
  parameter int FRAC  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          rnd_mode,
  input  logic [LANES*DW-1:0] vector,
  input  logic [LANES*DW-1:0] matrix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] result,
  output logic [LANES-1:0]    sat
);
  logic [2:0]          r_vld;
  logic [LANES*DW-1:0] r_a, r_b;
  logic [1:0]          r_mode0, r_mode1;
  logic                w_ld0, w_ld1, w_ld2;

  // Each stage advances when empty or when its successor advances, so bubbles collapse.
  assign w_ld2    = !r_vld[2] || out_ready;
  assign w_ld1    = !r_vld[1] || w_ld2;
  assign w_ld0    = !r_vld[0] || w_ld1;
  assign in_ready = w_ld0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode0 <= RND_TRUNC;
      r_mode1 <= RND_TRUNC;
    end else begin
      if (w_ld0) begin
        r_vld[0] <= in_valid;
        r_a      <= vector;
        r_b      <= matrix;
        r_mode0  <= rnd_mode;
      end
      if (w_ld1) begin
        r_vld[1] <= r_vld[0];
        r_mode1  <= r_mode0;
      end
      if (w_ld2) r_vld[2] <= r_vld[1];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LO = lane_lo(i, DW);
    vecmat_mul_lane #(.DW(DW), .FRAC(FRAC)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_ld1  (w_ld1),
      .i_ld2  (w_ld2),
      .i_a    (r_a[LO +: DW]),
      .i_b    (r_b[LO +: DW]),
      .i_mode (r_mode1),
      .o_res  (result[LO +: DW]),
      .o_sat  (sat[i])
    );
  end

  assign out_valid = r_vld[2];
endmodule

// File: doc/vecmat_mul_stream.md
Name: vecmat_mul_stream

Overview:
Parametrised successor to the fixed 64-lane, 16-bit elementwise multiplier in the attention-layer datapath. It multiplies LANES signed fixed-point element pairs (Q-vector by K/V-matrix row) per beat and rescales each product by FRAC bits. Rounding is selectable and every lane saturates. The pipeline is 3 stages with a valid/ready handshake and full backpressure, and sits between the buffer-RAM readers and the adder tree / softmax front end.

Parameters:
LANES, 64, number of parallel multiplier lanes
DW, 16, element width (signed two's complement, input and output)
FRAC, 12, fractional bits; product is right-shifted by FRAC (1 <= FRAC <= 2*DW-2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
rnd_mode  in  2  per-beat rounding: 0 trunc toward zero, 1 floor, 2 round-half-away-from-zero, 3 treated as 0
vector  in  LANES*DW  operand A; lane i at [i*DW +: DW]
matrix  in  LANES*DW  operand B; same packing as vector
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
result  out  LANES*DW  scaled, rounded, saturated products; same packing as the operands
sat  out  LANES  per-lane flag: the lane result was clamped

Behaviour:
- Reset (async, immediate): all stage valids = 0, out_valid = 0, result = 0, sat = 0. in_ready = 1 once reset deasserts.
- Transfer rules: an input beat transfers when in_valid & in_ready. An output beat transfers when out_valid & out_ready.
- Stages:
  - S0 registers the operands and rnd_mode.
  - S1 registers the full signed product P (2*DW bits) per lane.
  - S2 registers the rescaled result and sat; S2 drives result, sat and out_valid directly.
- Stage enables: S2 loads when !v2 | out_ready. Stage k (k = 0, 1) loads when !v_k | load_{k+1}. in_ready = load_0, combinational from that chain. Bubbles collapse.
- Latency is 3 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle while out_ready = 1.
- Held registers: while out_valid & !out_ready, result and sat hold stable. Data and valids in stalled stages hold.
- Capacity: at most 3 beats in flight. Beats are never dropped or duplicated, and order is preserved.
- Rescale, per lane on P, with R computed at full width before saturation:
  - mode 0: R = sign(P)*(|P| >> FRAC).
  - mode 1: R = P >>> FRAC.
  - mode 2: R = sign(P)*((|P| + 2^(FRAC-1)) >> FRAC).
- Saturation: if R > 2^(DW-1)-1, the lane result = 2^(DW-1)-1 and sat[i] = 1. If R < -2^(DW-1), the lane result = -2^(DW-1) and sat[i] = 1. Otherwise the lane result = R[DW-1:0] and sat[i] = 0.
- The |P| path must handle P = 2^(2DW-2) (min*min) without overflow: use a 2*DW+1-bit intermediate.
- Simultaneous output and input transfer with a full pipe: all stages advance, and in_ready stays 1.
- No state machine beyond the per-stage valid bits. Reset mid-operation discards all in-flight beats.
- Lanes are independent; there is no cross-lane arithmetic.

Decomposition:
- Shared package: rounding-mode constants (RND_TRUNC = 0, RND_FLOOR = 1, RND_RHAZ = 2) and a lane-slice helper macro/function for [i*DW +: DW].
- One natural sub-module, vecmat_mul_lane:
  - contents: one lane's S1 product register plus the S2 rescale/saturate logic;
  - driven by the top-level stage enables;
  - generate-instantiated LANES times.
- The top level owns the S0 registers, all valid/enable logic and the handshake.

Test Plan:
LANES=4, DW=16, FRAC=12.
- Basic: a = 0x1000, b = 0x1000 all lanes, mode 0 -> result lanes 0x1000, sat = 0, out_valid exactly 3 cycles after transfer. Also a = 0x2000, b = 0xE000 -> 0xC000.
- Rounding: lane0 a = 0x0001, b = 0x0800 (P = +2048); lane1 a = 0xFFFF, b = 0x0800 (P = -2048).
  - mode 0 -> 0x0000 / 0x0000;
  - mode 1 -> 0x0000 / 0xFFFF;
  - mode 2 -> 0x0001 / 0xFFFF.
- Saturation:
  - a = b = 0x7FFF -> 0x7FFF, sat = 1;
  - a = b = 0x8000 -> 0x7FFF, sat = 1;
  - a = 0x7FFF, b = 0x8000 -> 0x8000, sat = 1;
  - a = 0x0100, b = 0x0100 -> 0x0010, sat = 0.
- Backpressure: in_valid = 1 with distinct data, out_ready = 0 for 10 cycles.
  - Exactly 3 beats are accepted, then in_ready = 0, and result holds stable.
  - Raise out_ready: beats emerge in order, 1/cycle, none lost.
- Random stall: random in_valid/out_ready for 2000 beats; a scoreboard checks against a reference model for all rnd_mode values.
- Reset mid-operation: assert reset while out_valid = 1 and the pipe is full -> out_valid, result and sat go to 0 in the same cycle with no clock edge. After release, none of the old beats appear.
